cla_multiword_sequencer: RTL
============================

Name: cla_multiword_sequencer

Overview:
- Sequential controller that performs wide (W*WORDS-bit) add/subtract operations by time-multiplexing a single W-bit carry-lookahead adder instance (carry_lookahead_generic, N=W).
- Processes one W-bit word per cycle, least significant word first, and keeps the inter-word carry in a register.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
- Trades latency for area against a full-width CLA.

Parameters:
- W, 16, word width fed to the adder instance; power of 2, >= 4.
- WORDS, 4, number of words per operand; >= 1; total width T = W*WORDS.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  sequencer can accept a request.
- op_sub  input  1  0 = add, 1 = subtract (a - b).
- a  input  T  operand A.
- b  input  T  operand B.
- cin  input  1  carry-in (add) / borrow-in (sub).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  T  sum or difference.
- cout  output  1  final carry-out; for sub, 1 = no borrow.
- overflow  output  1  signed (two's-complement) overflow of the T-bit operation.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Single clock domain. Reset is synchronous and active-high; the clock port is clk and the reset port is rst.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, cout=0, overflow=0, word index=0, carry reg=0.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready:
    - latch a into opA;
    - latch b into opB, or ~b if op_sub;
    - carry reg <= cin for add, ~cin for sub (sub computes a + ~b + ~cin, i.e. a - b - cin);
    - idx <= 0; go to RUN.
  - RUN: in_ready=0. Each cycle:
    - adder gets opA word idx, opB word idx, and the carry reg;
    - result word idx <= adder sum; carry reg <= adder cout.
    - If idx == WORDS-1: cout <= adder cout; overflow <= carry into MSB XOR adder cout, where carry into MSB = opA[T-1] ^ opB[T-1] ^ sum[W-1]; go to DONE.
    - Otherwise idx <= idx+1.
  - DONE: out_valid=1. result, cout and overflow are held stable. On out_ready go to IDLE with out_valid=0.
- Latency: the acceptance edge is cycle 0; out_valid is high from cycle WORDS+1 (RUN occupies cycles 1..WORDS).
- Minimum initiation interval: WORDS+2 cycles. No accept in the same cycle as the output handshake.
- WORDS=1: RUN lasts exactly one cycle.
- in_valid while busy: ignored. No latch, no side effects. Operands need only be stable on the acceptance cycle.
- out_ready while not DONE: ignored.
- result is written word-by-word during RUN. Its value is only defined when out_valid=1; it is cleared to 0 on reset only.
- Reset mid-RUN or mid-DONE: abort immediately. The next cycle is IDLE with reset values. The partial result is discarded and no out_valid pulse is produced.
- Arithmetic: T-bit modular result. Signed overflow is computed per two's-complement rules for the effective a + opB + carry0.

Test Plan:
- Add carry ripple (W=16, WORDS=4): a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0, op_sub=0 -> result=0, cout=1, overflow=0; out_valid rises exactly 5 cycles after the accept edge; in_ready=0 throughout.
- Subtract with borrow: a=5, b=7, cin=0, op_sub=1 -> result=0xFFFF_FFFF_FFFF_FFFE, cout=0, overflow=0.
- Signed overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=1, add -> result=0x8000_0000_0000_0000, overflow=1, cout=0. Also a=0x8000_0000_0000_0000, b=1, sub -> result=0x7FFF_FFFF_FFFF_FFFF, overflow=1, cout=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while driving in_valid=1 with new operands -> result, cout and overflow are unchanged; in_ready=0. After out_ready=1 for one cycle: IDLE, and the pending request is accepted on the next edge.
- Reset mid-op: assert rst for one cycle when idx=2 -> next cycle in_ready=1, out_valid=0, busy=0, result=0. A subsequent add 3+4 gives 7 with correct latency.
- Random regression: 2000 back-to-back random add/sub operations with random cin and random out_ready stalls, run for WORDS=4 and WORDS=1 -> every result, cout and overflow matches the reference model; out_valid never drops before the handshake.

Source files
------------

// File: rtl/cla_multiword_sequencer.sv
// Wide add/subtract built from one W-bit carry-lookahead adder reused once per word,
// least significant word first, with the inter-word carry kept in a register.

module carry_lookahead_generic #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    localparam int LEVELS = $clog2(N);

    logic [N-1:0] p_s;
    logic [N-1:0] g_s;
    logic [N-1:0] carry_s;
    logic [N-1:0] gl_s [0:LEVELS];
    logic [N-1:0] pl_s [0:LEVELS];

    assign p_s = a ^ b;
    assign g_s = a & b;

    // Kogge-Stone prefix tree; cin is folded into bit 0 so gl_s[LEVELS][i] is the carry out of bit i
    always_comb begin
        gl_s[0]    = g_s;
        pl_s[0]    = p_s;
        gl_s[0][0] = g_s[0] | (p_s[0] & cin);
        for (int l = 0; l < LEVELS; l++) begin
            for (int i = 0; i < N; i++) begin
                if (i >= (1 << l)) begin
                    gl_s[l+1][i] = gl_s[l][i] | (pl_s[l][i] & gl_s[l][(i >= (1 << l)) ? (i - (1 << l)) : 0]);
                    pl_s[l+1][i] = pl_s[l][i] & pl_s[l][(i >= (1 << l)) ? (i - (1 << l)) : 0];
                end else begin
                    gl_s[l+1][i] = gl_s[l][i];
                    pl_s[l+1][i] = pl_s[l][i];
                end
            end
        end
    end

    // Carry into each bit position
    always_comb begin
        carry_s = {gl_s[LEVELS][N-2:0], cin};
    end

    assign sum  = p_s ^ carry_s;
    assign cout = gl_s[LEVELS][N-1];
endmodule

module cla_multiword_sequencer #(
    parameter int W     = 16,
    parameter int WORDS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [W*WORDS-1:0] a,
    input  logic [W*WORDS-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W*WORDS-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             busy
);
    localparam int T  = W * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_n;
    logic [T-1:0]    op_a_r;
    logic [T-1:0]    op_b_r;
    logic            carry_r;
    logic [IW-1:0]   idx_r;
    logic [T-1:0]    result_r;
    logic            cout_r;
    logic            overflow_r;
    logic            in_ready_r;
    logic            out_valid_r;
    logic            busy_r;

    logic [W-1:0]    word_a_s;
    logic [W-1:0]    word_b_s;
    logic [W-1:0]    sum_s;
    logic            carry_out_s;
    logic            last_s;
    logic            msb_carry_s;

    assign word_a_s    = op_a_r[32'(idx_r) * W +: W];
    assign word_b_s    = op_b_r[32'(idx_r) * W +: W];
    assign last_s      = (idx_r == LAST_IDX);
    // Carry into the top bit, recovered from the top-word sum bit and its operand bits
    assign msb_carry_s = op_a_r[T-1] ^ op_b_r[T-1] ^ sum_s[W-1];

    carry_lookahead_generic #(
        .N(W)
    ) u_cla (
        .a   (word_a_s),
        .b   (word_b_s),
        .cin (carry_r),
        .sum (sum_s),
        .cout(carry_out_s)
    );

    // Next-state decode
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_n = RUN;
                end else begin
                    state_n = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_n = DONE;
                end else begin
                    state_n = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end else begin
                    state_n = DONE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State register and registered handshake flags derived from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_n;
            in_ready_r  <= (state_n == IDLE);
            out_valid_r <= (state_n == DONE);
            busy_r      <= (state_n != IDLE);
        end
    end

    // Operand capture and word-serial datapath; subtract is a + ~b + ~cin
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a_r     <= {T{1'b0}};
            op_b_r     <= {T{1'b0}};
            carry_r    <= 1'b0;
            idx_r      <= {IW{1'b0}};
            result_r   <= {T{1'b0}};
            cout_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        op_a_r  <= a;
                        op_b_r  <= op_sub ? ~b : b;
                        carry_r <= op_sub ? ~cin : cin;
                        idx_r   <= {IW{1'b0}};
                    end
                end
                RUN: begin
                    result_r[32'(idx_r) * W +: W] <= sum_s;
                    carry_r                       <= carry_out_s;
                    if (last_s) begin
                        cout_r     <= carry_out_s;
                        overflow_r <= msb_carry_s ^ carry_out_s;
                    end else begin
                        idx_r <= idx_r + IDX_ONE;
                    end
                end
                DONE: begin
                    cout_r <= cout_r;
                end
                default: begin
                    idx_r <= {IW{1'b0}};
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign result    = result_r;
    assign cout      = cout_r;
    assign overflow  = overflow_r;
endmodule
